rf_multiport_sb: RTL and testbench
==================================

// Module: rf_multiport_sb
// PURPOSE
//  Parametrised GPR file for the NPC core: 1 write port, NUM_RD combinational read ports, optional
//  write-to-read bypass, hardwired zero register and per-register busy scoreboard.
//  Sits between decode (reads, issue) and writeback (write); replaces the single-read-port file.
//  A debug read port serves the simulator/difftest register dump.
// PARAMETERS
//  ADDR_WIDTH  5   register index width; depth = 2**ADDR_WIDTH
//  DATA_WIDTH  32  register width in bits
//  NUM_RD      2   number of architectural read ports (>=1)
//  BYPASS      1   1: same-cycle write data forwarded to reads and busy queries; 0: no forwarding
//  ZERO_REG    1   1: index 0 reads 0 and ignores writes/issue; 0: index 0 is ordinary
// PORTS
//  clk        in   1                    clock, rising edge
//  rst        in   1                    asynchronous reset, active high
//  wen        in   1                    writeback valid
//  waddr      in   ADDR_WIDTH           writeback index
//  wdata      in   DATA_WIDTH           writeback data
//  raddr      in   NUM_RD*ADDR_WIDTH    read indices, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//  rdata      out  NUM_RD*DATA_WIDTH    read data, port i at [i*DATA_WIDTH +: DATA_WIDTH]
//  rbusy      out  NUM_RD               1 = operand i still pending (decode must stall)
//  issue_vld  in   1                    instruction issued, will write issue_rd
//  issue_rd   in   ADDR_WIDTH           destination index of issued instruction
//  dbg_raddr  in   ADDR_WIDTH           debug read index
//  dbg_rdata  out  DATA_WIDTH           debug read data (array contents, never bypassed)
// BEHAVIOUR
//  - Reset (async, rst=1): all array entries <= 0, all busy bits <= 0. Consequently rdata=0,
//    rbusy=0, dbg_rdata=0 while in reset. Reset mid-operation discards pending writes/issues.
//  - Write: at posedge, wen=1 -> rf[waddr] <= wdata. ZERO_REG=1 and waddr=0 -> write dropped.
//  - Read: combinational, 0-cycle latency. Priority per port i:
//      ZERO_REG & raddr_i==0 -> 0; else BYPASS & wen & waddr==raddr_i -> wdata; else rf[raddr_i].
//    All NUM_RD ports independent; identical indices on several ports legal.
//  - Scoreboard busy[2**ADDR_WIDTH], registered:
//      set:   issue_vld & !(ZERO_REG & issue_rd==0) -> busy[issue_rd] <= 1
//      clear: wen -> busy[waddr] <= 0
//      same index set+clear in one cycle -> set wins (newer producer outstanding).
//      issue to an already-busy index: stays 1 (no counting; decode guarantees no WAW in flight).
//      wen to non-busy index: legal, busy stays 0.
//  - rbusy[i] = busy[raddr_i] & !(ZERO_REG & raddr_i==0) & !(BYPASS & wen & waddr==raddr_i).
//  - dbg_rdata = rf[dbg_raddr] (0 for index 0 when ZERO_REG=1); no bypass, no busy masking.
//  - No X on outputs after reset for any in-range index; all indices are in range by construction.
// STRUCTURE
//  - rf_pkg: RF_ADDR_W=5, RF_DATA_W=32, RF_ZERO_IDX=0, typedef rf_idx_t / rf_data_t.
//  - Sub-module rf_scoreboard (busy vector, set/clear priority, per-port query with bypass mask);
//    storage array, read muxes and debug port stay in the top.
//  - Read muxes via generate loop over NUM_RD.
// TESTING
//  1 Reset: pulse rst mid-simulation after writing r5=0x1234 -> dbg_rdata(r5)=0, rbusy all 0, async
//    (observed before next clk edge).
//  2 Zero reg: wen waddr=0 wdata=0xDEADBEEF; issue_rd=0 -> raddr=0 gives 0, rbusy=0 next cycle.
//  3 Write/read: write r3=0xA5A5A5A5; next cycle both ports raddr=3 -> 0xA5A5A5A5 on both.
//  4 Bypass: same cycle wen waddr=7 wdata=0x55, raddr0=7 -> rdata0=0x55 (BYPASS=1), old value
//    (BYPASS=0); dbg_rdata(7) shows old value until edge.
//  5 Scoreboard: issue r9 -> next cycle rbusy=1 for raddr=9; wen r9 -> rbusy=0 same cycle (BYPASS=1),
//    busy cleared after edge; issue r9 & wen r9 same cycle -> busy stays 1.
//  6 Random: NUM_RD=3, 10k cycles random wen/issue/raddr vs reference model, compare every cycle.

Source files
------------

// File: rtl/rf_multiport_sb_pkg.sv
// Shared widths and index/data types for the NPC general-purpose register file.
package rf_pkg;

    localparam int unsigned RF_ADDR_W   = 5;
    localparam int unsigned RF_DATA_W   = 32;
    localparam int unsigned RF_ZERO_IDX = 0;

    typedef logic [RF_ADDR_W-1:0] rf_idx_t;
    typedef logic [RF_DATA_W-1:0] rf_data_t;

endpackage

// File: rtl/rf_multiport_sb_scoreboard.sv
// Per-register busy scoreboard: set on issue, cleared on writeback, queried per read port.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = RF_ADDR_W,
    parameter int unsigned NUM_RD     = 2,
    parameter int unsigned BYPASS     = 1,
    parameter int unsigned ZERO_REG   = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wen,
    input  logic [ADDR_WIDTH-1:0]        waddr,
    input  logic                         issue_vld,
    input  logic [ADDR_WIDTH-1:0]        issue_rd,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] raddr,
    output logic [NUM_RD-1:0]            rbusy
);

    localparam int unsigned           DEPTH = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZIDX  = ADDR_WIDTH'(RF_ZERO_IDX);

    logic [DEPTH-1:0] busy;
    logic             set_ok;

    assign set_ok = issue_vld && !(ZERO_REG != 0 && issue_rd == ZIDX);

    // Set is assigned after clear so a newer producer wins on a same-index collision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            if (wen)
                busy[waddr] <= 1'b0;
            if (set_ok)
                busy[issue_rd] <= 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_q
        logic [ADDR_WIDTH-1:0] ra;
        assign ra = raddr[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign rbusy[i] = busy[ra]
                        && !(ZERO_REG != 0 && ra == ZIDX)
                        && !(BYPASS != 0 && wen && waddr == ra);
    end

endmodule

// File: rtl/rf_multiport_sb.sv
// Multi-read-port GPR file with optional write bypass, hardwired zero register,
// busy scoreboard and an unbypassed debug read port for register dumps.
module rf_multiport_sb
    import rf_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = RF_ADDR_W,
    parameter int unsigned DATA_WIDTH = RF_DATA_W,
    parameter int unsigned NUM_RD     = 2,
    parameter int unsigned BYPASS     = 1,
    parameter int unsigned ZERO_REG   = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wen,
    input  logic [ADDR_WIDTH-1:0]        waddr,
    input  logic [DATA_WIDTH-1:0]        wdata,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] raddr,
    output logic [NUM_RD*DATA_WIDTH-1:0] rdata,
    output logic [NUM_RD-1:0]            rbusy,
    input  logic                         issue_vld,
    input  logic [ADDR_WIDTH-1:0]        issue_rd,
    input  logic [ADDR_WIDTH-1:0]        dbg_raddr,
    output logic [DATA_WIDTH-1:0]        dbg_rdata
);

    localparam int unsigned           DEPTH = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZIDX  = ADDR_WIDTH'(RF_ZERO_IDX);

    logic [DATA_WIDTH-1:0] rf [DEPTH];
    logic                  wr_ok;

    assign wr_ok = wen && !(ZERO_REG != 0 && waddr == ZIDX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rf <= '{default: '0};
        else if (wr_ok)
            rf[waddr] <= wdata;
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_WIDTH-1:0] ra;
        assign ra = raddr[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign rdata[i*DATA_WIDTH +: DATA_WIDTH] =
            (ZERO_REG != 0 && ra == ZIDX)        ? '0    :
            (BYPASS != 0 && wen && waddr == ra)  ? wdata :
                                                   rf[ra];
    end

    assign dbg_rdata = (ZERO_REG != 0 && dbg_raddr == ZIDX) ? '0 : rf[dbg_raddr];

    rf_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_RD     (NUM_RD),
        .BYPASS     (BYPASS),
        .ZERO_REG   (ZERO_REG)
    ) u_sb (
        .clk       (clk),
        .rst       (rst),
        .wen       (wen),
        .waddr     (waddr),
        .issue_vld (issue_vld),
        .issue_rd  (issue_rd),
        .raddr     (raddr),
        .rbusy     (rbusy)
    );

endmodule

// File: tb/tb_rf_multiport_sb.sv
// Bench for rf_multiport_sb: three configurations share stimulus and are checked against an array model.
module tb_rf_multiport_sb;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int NR = 3;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 wen;
    logic [AW-1:0]        waddr;
    logic [DW-1:0]        wdata;
    logic [NR*AW-1:0]     raddr;
    logic                 issue_vld;
    logic [AW-1:0]        issue_rd;
    logic [AW-1:0]        dbg_raddr;

    logic [2:0][NR*DW-1:0] rdata_a;
    logic [2:0][NR-1:0]    rbusy_a;
    logic [2:0][DW-1:0]    dbg_a;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // config 0: bypass + zero reg, config 1: no bypass + zero reg, config 2: bypass, ordinary r0
    rf_multiport_sb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RD(NR), .BYPASS(1), .ZERO_REG(1)) dut_b1z1 (
        .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata), .raddr(raddr),
        .rdata(rdata_a[0]), .rbusy(rbusy_a[0]), .issue_vld(issue_vld), .issue_rd(issue_rd),
        .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_a[0]));
    rf_multiport_sb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RD(NR), .BYPASS(0), .ZERO_REG(1)) dut_b0z1 (
        .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata), .raddr(raddr),
        .rdata(rdata_a[1]), .rbusy(rbusy_a[1]), .issue_vld(issue_vld), .issue_rd(issue_rd),
        .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_a[1]));
    rf_multiport_sb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RD(NR), .BYPASS(1), .ZERO_REG(0)) dut_b1z0 (
        .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata), .raddr(raddr),
        .rdata(rdata_a[2]), .rbusy(rbusy_a[2]), .issue_vld(issue_vld), .issue_rd(issue_rd),
        .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_a[2]));

    logic [DW-1:0] m_mem  [3][32];
    bit            m_busy [3][32];

    function automatic bit cfg_byp(int c); return c != 1; endfunction
    function automatic bit cfg_zr(int c);  return c != 2; endfunction

    function automatic logic [DW-1:0] exp_rdata(int c, logic [AW-1:0] a);
        if (cfg_zr(c) && a == 0) return '0;
        if (cfg_byp(c) && wen && waddr == a) return wdata;
        return m_mem[c][a];
    endfunction

    function automatic logic exp_rbusy(int c, logic [AW-1:0] a);
        if (cfg_zr(c) && a == 0) return 1'b0;
        if (cfg_byp(c) && wen && waddr == a) return 1'b0;
        return m_busy[c][a];
    endfunction

    function automatic logic [DW-1:0] exp_dbg(int c, logic [AW-1:0] a);
        if (cfg_zr(c) && a == 0) return '0;
        return m_mem[c][a];
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 3; c++)
            for (int r = 0; r < 32; r++) begin
                m_mem[c][r]  = '0;
                m_busy[c][r] = 1'b0;
            end
    endtask

    task automatic model_commit();
        for (int c = 0; c < 3; c++) begin
            if (wen && !(cfg_zr(c) && waddr == 0)) m_mem[c][waddr] = wdata;
            if (wen) m_busy[c][waddr] = 1'b0;
            if (issue_vld && !(cfg_zr(c) && issue_rd == 0)) m_busy[c][issue_rd] = 1'b1;
        end
    endtask

    task automatic chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        for (int c = 0; c < 3; c++) begin
            for (int p = 0; p < NR; p++) begin
                chk($sformatf("cfg%0d rdata%0d", c, p), rdata_a[c][p*DW +: DW], exp_rdata(c, raddr[p*AW +: AW]));
                chk($sformatf("cfg%0d rbusy%0d", c, p), DW'(rbusy_a[c][p]), DW'(exp_rbusy(c, raddr[p*AW +: AW])));
            end
            chk($sformatf("cfg%0d dbg_rdata", c), dbg_a[c], exp_dbg(c, dbg_raddr));
        end
    endtask

    task automatic to_neg();
        @(negedge clk);
        check_all();
    endtask

    task automatic finish_cycle();
        model_commit();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wen = 1'b0; waddr = '0; wdata = '0; issue_vld = 1'b0; issue_rd = '0;
    endtask

    typedef struct {
        logic          wen;
        logic [AW-1:0] waddr;
        logic [DW-1:0] wdata;
        logic          iv;
        logic [AW-1:0] ird;
        logic [AW-1:0] ra0;
        logic [AW-1:0] ra1;
        logic [DW-1:0] e0;
        logic [DW-1:0] e1;
        logic [1:0]    eb;
        logic [DW-1:0] enb;
    } vec_t;

    vec_t tbl [15];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //           wen waddr  wdata         iv ird  ra0 ra1  e0            e1            eb     enb
        tbl[0]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd5, 5'd5, 32'h0,        32'h0,        2'b00, 32'h0};
        tbl[1]  = '{1'b1, 5'd0,  32'hDEADBEEF, 1'b1, 5'd0, 5'd0, 5'd0, 32'h0,        32'h0,        2'b00, 32'h0};
        tbl[2]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd0, 5'd0, 32'h0,        32'h0,        2'b00, 32'h0};
        tbl[3]  = '{1'b1, 5'd3,  32'hA5A5A5A5, 1'b0, 5'd0, 5'd3, 5'd1, 32'hA5A5A5A5, 32'h0,        2'b00, 32'h0};
        tbl[4]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd3, 5'd3, 32'hA5A5A5A5, 32'hA5A5A5A5, 2'b00, 32'hA5A5A5A5};
        tbl[5]  = '{1'b1, 5'd7,  32'h11,       1'b0, 5'd0, 5'd7, 5'd7, 32'h11,       32'h11,       2'b00, 32'h0};
        tbl[6]  = '{1'b1, 5'd7,  32'h55,       1'b0, 5'd0, 5'd7, 5'd3, 32'h55,       32'hA5A5A5A5, 2'b00, 32'h11};
        tbl[7]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd9, 5'd9, 5'd9, 32'h0,        32'h0,        2'b00, 32'h0};
        tbl[8]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd9, 5'd3, 32'h0,        32'hA5A5A5A5, 2'b01, 32'h0};
        tbl[9]  = '{1'b1, 5'd9,  32'h99,       1'b0, 5'd0, 5'd9, 5'd9, 32'h99,       32'h99,       2'b00, 32'h0};
        tbl[10] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd9, 5'd9, 32'h99,       32'h99,       2'b00, 32'h99};
        tbl[11] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd9, 5'd9, 5'd9, 32'h99,       32'h99,       2'b00, 32'h99};
        tbl[12] = '{1'b1, 5'd9,  32'h100,      1'b1, 5'd9, 5'd9, 5'd9, 32'h100,      32'h100,      2'b00, 32'h99};
        tbl[13] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd9, 5'd9, 32'h100,      32'h100,      2'b11, 32'h100};
        tbl[14] = '{1'b1, 5'd12, 32'h12,       1'b0, 5'd0, 5'd9, 5'd12, 32'h100,     32'h12,       2'b01, 32'h100};

        rst = 1'b1;
        idle();
        raddr = '0;
        dbg_raddr = '0;
        model_reset();
        #2;
        check_all();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int v = 0; v < 15; v++) begin
            wen = tbl[v].wen; waddr = tbl[v].waddr; wdata = tbl[v].wdata;
            issue_vld = tbl[v].iv; issue_rd = tbl[v].ird;
            raddr = {5'd0, tbl[v].ra1, tbl[v].ra0};
            to_neg();
            chk($sformatf("vec%0d rdata0", v), rdata_a[0][0 +: DW], tbl[v].e0);
            chk($sformatf("vec%0d rdata1", v), rdata_a[0][DW +: DW], tbl[v].e1);
            chk($sformatf("vec%0d rbusy", v), DW'(rbusy_a[0][1:0]), DW'(tbl[v].eb));
            chk($sformatf("vec%0d nobyp rdata0", v), rdata_a[1][0 +: DW], tbl[v].enb);
            finish_cycle();
        end

        // debug port must show array contents, not the in-flight write
        wen = 1'b1; waddr = 5'd7; wdata = 32'h77; dbg_raddr = 5'd7;
        raddr = {5'd0, 5'd0, 5'd7};
        to_neg();
        chk("dbg pre-edge", dbg_a[0], 32'h55);
        chk("byp rdata r7", rdata_a[0][0 +: DW], 32'h77);
        chk("nobyp rdata r7", rdata_a[1][0 +: DW], 32'h55);
        finish_cycle();
        idle();
        to_neg();
        chk("dbg post-edge", dbg_a[0], 32'h77);
        finish_cycle();

        // asynchronous reset mid-operation
        wen = 1'b1; waddr = 5'd5; wdata = 32'h1234; issue_vld = 1'b1; issue_rd = 5'd6;
        to_neg();
        finish_cycle();
        idle();
        raddr = {5'd6, 5'd5, 5'd6};
        dbg_raddr = 5'd5;
        #1;
        chk("pre-rst dbg r5", dbg_a[0], 32'h1234);
        chk("pre-rst rbusy r6", DW'(rbusy_a[0][0]), 32'h1);
        #1;
        rst = 1'b1;
        #1;
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("async rst cfg%0d dbg", c), dbg_a[c], 32'h0);
            chk($sformatf("async rst cfg%0d rbusy", c), DW'(rbusy_a[c]), 32'h0);
            chk($sformatf("async rst cfg%0d rdata1", c), rdata_a[c][DW +: DW], 32'h0);
        end
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        to_neg();
        finish_cycle();

        for (int n = 0; n < 10000; n++) begin
            wen       = 1'($urandom_range(0, 1));
            waddr     = AW'($urandom_range(0, 15));
            wdata     = $urandom;
            issue_vld = 1'($urandom_range(0, 1));
            issue_rd  = AW'($urandom_range(0, 15));
            for (int p = 0; p < NR; p++)
                raddr[p*AW +: AW] = ($urandom_range(0, 3) == 0) ? waddr : AW'($urandom_range(0, 15));
            dbg_raddr = ($urandom_range(0, 3) == 0) ? waddr : AW'($urandom_range(0, 31));
            to_neg();
            finish_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
